// File: rtl/cpu_pkg.sv
// Shared definitions for the data-memory access path.
// State encoding and default wait-state latencies.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_LAT = 2;
    localparam int DEF_WR_LAT = 1;
    localparam int CNT_W      = 3;

    // Counter preload for a latency of lat cycles (counts lat-1 .. 0).
    function automatic logic [CNT_W-1:0] lat_preload(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable 3-bit down-counter with zero flag.
// Shared by the read and write wait phases.
module wait_counter
    import cpu_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_wait_ctrl.sv
// Data-memory access sequencer: fixed wait-state RAM transactions
// with a clock-enable style pipeline stall.
module mem_wait_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int WR_LAT = DEF_WR_LAT
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              memtoreg,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_valid,
    output logic              conflict,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t           state;
    state_t           state_nx;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    wait_counter u_cnt (
        .clk_in   (clk_in),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (memtoreg)      state_nx = RD_WAIT;
                else if (memwrite) state_nx = WR_WAIT;
            end
            RD_WAIT: if (cnt_zero) state_nx = DONE;
            WR_WAIT: if (cnt_zero) state_nx = DONE;
            DONE:    state_nx = IDLE;
        endcase
    end

    // Stall is gated by reset so an aborted request cannot hold the pipe.
    always_comb begin
        stall    = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        unique case (state)
            IDLE: begin
                stall    = memtoreg | memwrite;
                cnt_load = memtoreg | memwrite;
                cnt_val  = memtoreg ? lat_preload(RD_LAT)
                                    : lat_preload(WR_LAT);
            end
            RD_WAIT, WR_WAIT: begin
                stall   = 1'b1;
                cnt_dec = 1'b1;
            end
            DONE: stall = 1'b0;
        endcase
        stall = stall & ~rst;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rdata_out   <= '0;
            rdata_valid <= 1'b0;
            conflict    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            conflict    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (memtoreg) begin
                        mem_addr <= addr;
                        mem_re   <= 1'b1;
                        conflict <= memwrite;
                    end else if (memwrite) begin
                        mem_addr  <= addr;
                        mem_wdata <= wdata;
                        mem_we    <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (cnt_zero) begin
                        rdata_out   <= mem_rdata;
                        rdata_valid <= 1'b1;
                        mem_re      <= 1'b0;
                    end
                end
                WR_WAIT: if (cnt_zero) mem_we <= 1'b0;
                DONE: ;
            endcase
        end
    end

endmodule
